// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter: round-robin arbiter that shares the lane's single VRF
// write-back port among NrReq VFU result producers. The winner is captured
// into a one-entry output register and handed to the VRF with valid/ready.
module vrf_wb_arbiter #(
  parameter int NrReq     = 4,
  parameter int DataWidth = 64,
  parameter int StrbWidth = 8,
  parameter int AddrWidth = 10,
  parameter int IdWidth   = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NrReq-1:0]             req_valid_i,
  input  logic [NrReq*DataWidth-1:0]   req_wdata_i,
  input  logic [NrReq*StrbWidth-1:0]   req_wstrb_i,
  input  logic [NrReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NrReq*IdWidth-1:0]     req_id_i,
  output logic [NrReq-1:0]             req_gnt_o,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic [DataWidth-1:0]         wb_wdata_o,
  output logic [StrbWidth-1:0]         wb_wstrb_o,
  output logic [AddrWidth-1:0]         wb_addr_o,
  output logic [IdWidth-1:0]           wb_id_o,
  output logic [$clog2(NrReq)-1:0]     wb_src_o,
  output logic                         busy_o
);

  localparam int SrcWidth = $clog2(NrReq);

  // Requester index `off` positions after `base`, wrapping at NrReq.
  function automatic logic [SrcWidth-1:0] rr_idx(input logic [SrcWidth-1:0] base,
                                                 input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NrReq) sum = sum - NrReq;
    return SrcWidth'(sum);
  endfunction

  logic [SrcWidth-1:0]  ptr;
  logic                 load_en;
  logic                 gnt_found;
  logic [SrcWidth-1:0]  gnt_idx;
  logic [DataWidth-1:0] sel_wdata;
  logic [StrbWidth-1:0] sel_wstrb;
  logic [AddrWidth-1:0] sel_addr;
  logic [IdWidth-1:0]   sel_id;

  // The output register can take a new write when empty or draining this cycle.
  assign load_en = !wb_valid_o || wb_ready_i;
  assign busy_o  = wb_valid_o || (|req_valid_i);

  // Round-robin search starting at ptr; no grant while in reset or stalled.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    req_gnt_o = '0;
    if (load_en && !rst_i) begin
      for (int off = 0; off < NrReq; off++) begin
        if (!gnt_found && req_valid_i[rr_idx(ptr, off)]) begin
          gnt_found = 1'b1;
          gnt_idx   = rr_idx(ptr, off);
        end
      end
    end
    if (gnt_found) req_gnt_o[gnt_idx] = 1'b1;
  end

  // Pick the winning requester's payload slice.
  always_comb begin
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_addr  = '0;
    sel_id    = '0;
    for (int i = 0; i < NrReq; i++) begin
      if (gnt_idx == SrcWidth'(i)) begin
        sel_wdata = req_wdata_i[i*DataWidth +: DataWidth];
        sel_wstrb = req_wstrb_i[i*StrbWidth +: StrbWidth];
        sel_addr  = req_addr_i[i*AddrWidth +: AddrWidth];
        sel_id    = req_id_i[i*IdWidth +: IdWidth];
      end
    end
  end

  // Output register: capture on grant, drop valid on a drain without refill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      wb_wdata_o <= '0;
      wb_wstrb_o <= '0;
      wb_addr_o  <= '0;
      wb_id_o    <= '0;
      wb_src_o   <= '0;
      ptr        <= '0;
    end else if (gnt_found) begin
      wb_valid_o <= 1'b1;
      wb_wdata_o <= sel_wdata;
      wb_wstrb_o <= sel_wstrb;
      wb_addr_o  <= sel_addr;
      wb_id_o    <= sel_id;
      wb_src_o   <= gnt_idx;
      ptr        <= rr_idx(gnt_idx, 1);
    end else if (wb_ready_i) begin
      wb_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// tb_vrf_wb_arbiter: directed and randomized checks of vrf_wb_arbiter
// against a simple round-robin/one-entry-register reference model.
module tb_vrf_wb_arbiter;

  localparam int NrReq     = 4;
  localparam int DataWidth = 64;
  localparam int StrbWidth = 8;
  localparam int AddrWidth = 10;
  localparam int IdWidth   = 3;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [NrReq-1:0]           req_valid_i;
  logic [NrReq*DataWidth-1:0] req_wdata_i;
  logic [NrReq*StrbWidth-1:0] req_wstrb_i;
  logic [NrReq*AddrWidth-1:0] req_addr_i;
  logic [NrReq*IdWidth-1:0]   req_id_i;
  logic [NrReq-1:0]           req_gnt_o;
  logic                       wb_valid_o;
  logic                       wb_ready_i;
  logic [DataWidth-1:0]       wb_wdata_o;
  logic [StrbWidth-1:0]       wb_wstrb_o;
  logic [AddrWidth-1:0]       wb_addr_o;
  logic [IdWidth-1:0]         wb_id_o;
  logic [1:0]                 wb_src_o;
  logic                       busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int                   m_ptr;
  bit                   m_valid;
  logic [DataWidth-1:0] m_data;
  logic [StrbWidth-1:0] m_strb;
  logic [AddrWidth-1:0] m_addr;
  logic [IdWidth-1:0]   m_id;
  int                   m_src;

  vrf_wb_arbiter #(
    .NrReq(NrReq), .DataWidth(DataWidth), .StrbWidth(StrbWidth),
    .AddrWidth(AddrWidth), .IdWidth(IdWidth)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_wdata_i(req_wdata_i),
    .req_wstrb_i(req_wstrb_i), .req_addr_i(req_addr_i), .req_id_i(req_id_i),
    .req_gnt_o(req_gnt_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_wdata_o(wb_wdata_o), .wb_wstrb_o(wb_wstrb_o), .wb_addr_o(wb_addr_o),
    .wb_id_o(wb_id_o), .wb_src_o(wb_src_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected winner from the model: -1 when nothing may be granted.
  function automatic int exp_grant();
    if (rst_i) return -1;
    if (m_valid && !wb_ready_i) return -1;
    for (int off = 0; off < NrReq; off++) begin
      if (req_valid_i[(m_ptr + off) % NrReq]) return (m_ptr + off) % NrReq;
    end
    return -1;
  endfunction

  function automatic logic [NrReq-1:0] grant_vec(input int g);
    logic [NrReq-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Advance one clock and update the model with the inputs seen at the edge.
  task automatic tick();
    int g;
    g = exp_grant();
    @(posedge clk_i);
    if (rst_i) begin
      m_valid = 0; m_ptr = 0; m_src = 0;
      m_data = '0; m_strb = '0; m_addr = '0; m_id = '0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_data  = req_wdata_i[g*DataWidth +: DataWidth];
      m_strb  = req_wstrb_i[g*StrbWidth +: StrbWidth];
      m_addr  = req_addr_i[g*AddrWidth +: AddrWidth];
      m_id    = req_id_i[g*IdWidth +: IdWidth];
      m_src   = g;
      m_ptr   = (g + 1) % NrReq;
    end else if (wb_ready_i) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic randomize_payloads();
    for (int k = 0; k < NrReq; k++) begin
      req_wdata_i[k*DataWidth +: DataWidth] = {$urandom, $urandom};
      req_wstrb_i[k*StrbWidth +: StrbWidth] =
        ($urandom_range(0, 3) == 0) ? '0 : StrbWidth'($urandom);
      req_addr_i[k*AddrWidth +: AddrWidth]  = AddrWidth'($urandom);
      req_id_i[k*IdWidth +: IdWidth]        = IdWidth'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = '0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    wb_ready_i = 1'b1;
    req_valid_i = '1;
    randomize_payloads();
    #1;
    n_checks++;
    if (req_gnt_o !== '0) $display("[TB] FAIL reset_gnt actual=%b required=0000", req_gnt_o);
    else n_pass++;
    tick();
    rst_i = 1'b0;
    req_valid_i = '0;
    #1;
    n_checks++;
    if ({wb_wdata_o, wb_wstrb_o, wb_addr_o, wb_id_o, wb_src_o} !== '0)
      $display("[TB] FAIL reset_payload actual=%h/%h/%h/%h/%0d required=all zero",
               wb_wdata_o, wb_wstrb_o, wb_addr_o, wb_id_o, wb_src_o);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (wb_valid_o !== 1'b0 || req_gnt_o !== '0 || busy_o !== 1'b0)
        $display("[TB] FAIL idle_cycle%0d actual valid=%b gnt=%b busy=%b required 0/0000/0",
                 c, wb_valid_o, req_gnt_o, busy_o);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_single();
    randomize_payloads();
    req_addr_i[0 +: AddrWidth] = 10'h010;
    req_id_i[0 +: IdWidth]     = 3'd2;
    req_valid_i = 4'b0001;
    wb_ready_i  = 1'b1;
    #1;
    n_checks++;
    if (req_gnt_o !== 4'b0001) $display("[TB] FAIL single_gnt actual=%b required=0001", req_gnt_o);
    else n_pass++;
    tick();
    req_valid_i = '0;
    #1;
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_addr_o !== 10'h010 || wb_id_o !== 3'd2 || wb_src_o !== 2'd0)
      $display("[TB] FAIL single_out actual valid=%b addr=%h id=%0d src=%0d required 1/010/2/0",
               wb_valid_o, wb_addr_o, wb_id_o, wb_src_o);
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    randomize_payloads();
    req_valid_i = 4'b1111;
    wb_ready_i  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (req_gnt_o !== 4'(1 << (c % 4)))
        $display("[TB] FAIL rr_gnt%0d actual=%b required=%b", c, req_gnt_o, 4'(1 << (c % 4)));
      else n_pass++;
      if (c > 0) begin
        n_checks++;
        if (wb_valid_o !== 1'b1 || int'(wb_src_o) != (c - 1) % 4)
          $display("[TB] FAIL rr_out%0d actual valid=%b src=%0d required 1/%0d",
                   c, wb_valid_o, wb_src_o, (c - 1) % 4);
        else n_pass++;
      end
      tick();
    end
    req_valid_i = '0;
    tick();
    tick();
  endtask

  task automatic test_stall();
    logic [DataWidth-1:0] hold_data;
    logic [AddrWidth-1:0] hold_addr;
    logic [IdWidth-1:0]   hold_id;
    do_reset();
    randomize_payloads();
    hold_data = req_wdata_i[2*DataWidth +: DataWidth];
    hold_addr = req_addr_i[2*AddrWidth +: AddrWidth];
    hold_id   = req_id_i[2*IdWidth +: IdWidth];
    req_valid_i = 4'b1111;
    wb_ready_i  = 1'b1;
    tick(); tick(); tick();
    wb_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      randomize_payloads();
      #1;
      n_checks++;
      if (req_gnt_o !== '0 || wb_valid_o !== 1'b1 || wb_src_o !== 2'd2 ||
          wb_wdata_o !== hold_data || wb_addr_o !== hold_addr || wb_id_o !== hold_id)
        $display("[TB] FAIL stall%0d actual gnt=%b valid=%b src=%0d addr=%h required 0000/1/2/%h",
                 c, req_gnt_o, wb_valid_o, wb_src_o, wb_addr_o, hold_addr);
      else n_pass++;
      tick();
    end
    wb_ready_i = 1'b1;
    #1;
    n_checks++;
    if (req_gnt_o !== 4'b1000) $display("[TB] FAIL stall_release actual=%b required=1000", req_gnt_o);
    else n_pass++;
    tick();
    req_valid_i = '0;
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    randomize_payloads();
    wb_ready_i  = 1'b1;
    req_valid_i = 4'b0100;
    tick();
    wb_ready_i  = 1'b0;
    req_valid_i = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (req_gnt_o !== '0) $display("[TB] FAIL withdraw_stall%0d actual=%b required=0000", c, req_gnt_o);
      else n_pass++;
      tick();
    end
    req_valid_i = '0;
    wb_ready_i  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (req_gnt_o !== '0) $display("[TB] FAIL withdraw_gnt%0d actual=%b required=0000", c, req_gnt_o);
      else n_pass++;
      tick();
      n_checks++;
      if (wb_valid_o !== 1'b0 || wb_src_o === 2'd1)
        $display("[TB] FAIL withdraw_out%0d actual valid=%b src=%0d required valid 0, src not 1",
                 c, wb_valid_o, wb_src_o);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    randomize_payloads();
    wb_ready_i  = 1'b1;
    req_valid_i = 4'b0100;
    tick();
    wb_ready_i  = 1'b0;
    req_valid_i = '0;
    #1;
    n_checks++;
    if (wb_valid_o !== 1'b1) $display("[TB] FAIL midrst_pre actual=%b required=1", wb_valid_o);
    else n_pass++;
    rst_i = 1'b1;
    req_valid_i = 4'b1111;
    #1;
    n_checks++;
    if (req_gnt_o !== '0) $display("[TB] FAIL midrst_gnt actual=%b required=0000", req_gnt_o);
    else n_pass++;
    tick();
    rst_i = 1'b0;
    req_valid_i = 4'b1010;
    wb_ready_i  = 1'b1;
    #1;
    n_checks++;
    if (wb_valid_o !== 1'b0 || req_gnt_o !== 4'b0010)
      $display("[TB] FAIL midrst_after actual valid=%b gnt=%b required 0/0010", wb_valid_o, req_gnt_o);
    else n_pass++;
    tick();
    req_valid_i = '0;
    tick();
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      randomize_payloads();
      req_valid_i = NrReq'($urandom);
      wb_ready_i  = ($urandom_range(0, 3) != 0);
      rst_i       = ($urandom_range(0, 49) == 0);
      #1;
      g = exp_grant();
      n_checks++;
      if (req_gnt_o !== grant_vec(g) || (req_gnt_o & ~req_valid_i) !== '0)
        $display("[TB] FAIL rand_gnt%0d actual=%b required=%b", c, req_gnt_o, grant_vec(g));
      else n_pass++;
      n_checks++;
      if (wb_valid_o !== m_valid || busy_o !== (m_valid || (|req_valid_i)))
        $display("[TB] FAIL rand_valid%0d actual valid=%b busy=%b required %b/%b",
                 c, wb_valid_o, busy_o, m_valid, m_valid || (|req_valid_i));
      else n_pass++;
      if (m_valid) begin
        n_checks++;
        if (wb_wdata_o !== m_data || wb_wstrb_o !== m_strb || wb_addr_o !== m_addr ||
            wb_id_o !== m_id || int'(wb_src_o) != m_src)
          $display("[TB] FAIL rand_payload%0d actual %h/%h/%h/%0d/%0d required %h/%h/%h/%0d/%0d",
                   c, wb_wdata_o, wb_wstrb_o, wb_addr_o, wb_id_o, wb_src_o,
                   m_data, m_strb, m_addr, m_id, m_src);
        else n_pass++;
      end
      tick();
    end
    rst_i = 1'b0;
    req_valid_i = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = '0;
    wb_ready_i = 1'b1;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    req_addr_i = '0;
    req_id_i = '0;
    m_ptr = 0; m_valid = 0; m_src = 0;
    m_data = '0; m_strb = '0; m_addr = '0; m_id = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vrf_wb_arbiter.md
Name: vrf_wb_arbiter

Overview:
- Shares the lane's single VRF write-back port among NrReq VFU result producers (VALU, and later VMUL and others).
- Arbitration is round-robin. The winning result is captured into a one-entry output register, then presented to the VRF write port with a valid/ready handshake.
- Sits between the VFU wrappers' result interfaces (wdata/wstrb/addr/id/valid/gnt) and the write side of the VRF accesser.
- Sustains one write per cycle when the downstream port is always ready.

Parameters:
- NrReq, 4, number of result requesters (one per lane VFU).
- DataWidth, 64, VRF write data width in bits.
- StrbWidth, 8, byte-strobe width (DataWidth/8).
- AddrWidth, 10, VRF address width.
- IdWidth, 3, instruction ID width.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NrReq  per-requester result valid.
- req_wdata_i  in  NrReq*DataWidth  per-requester write data, packed, requester i at slice i.
- req_wstrb_i  in  NrReq*StrbWidth  per-requester byte strobes.
- req_addr_i  in  NrReq*AddrWidth  per-requester VRF address.
- req_id_i  in  NrReq*IdWidth  per-requester instruction ID.
- req_gnt_o  out  NrReq  one-hot acceptance; payload captured this cycle.
- wb_valid_o  out  1  output register holds a pending write.
- wb_ready_i  in  1  VRF write port accepts the write this cycle.
- wb_wdata_o  out  DataWidth  registered write data.
- wb_wstrb_o  out  StrbWidth  registered strobes.
- wb_addr_o  out  AddrWidth  registered address.
- wb_id_o  out  IdWidth  registered instruction ID.
- wb_src_o  out  $clog2(NrReq)  index of the requester that owns the current output.
- busy_o  out  1  equals wb_valid_o | (|req_valid_i).

Behaviour:
- Reset (rst_i=1 at an edge): wb_valid_o=0; wb_wdata_o, wb_wstrb_o, wb_addr_o, wb_id_o, wb_src_o all 0; priority pointer ptr=0.
  - req_gnt_o is combinational and is all-zero while rst_i=1.
  - Reset mid-transfer discards the held write; no write-back is issued for it.
- Load enable: load_en = !wb_valid_o | wb_ready_i. The register may be refilled in the same cycle it drains.
- Grant (combinational):
  - If load_en=1 and any req_valid_i is set, req_gnt_o is one-hot at the first valid requester, searching ptr, ptr+1, ... modulo NrReq.
  - Otherwise req_gnt_o=0.
  - req_gnt_o[i] never asserts without req_valid_i[i].
- Capture on a grant to requester k:
  - Next edge: output register <= slice k of data/strb/addr/id; wb_src_o<=k; wb_valid_o<=1; ptr<=(k+1) mod NrReq.
  - Latency: grant cycle to wb_valid_o is exactly 1 cycle.
- Drain with no grant: if wb_valid_o=1, wb_ready_i=1 and no grant occurs, then wb_valid_o<=0. Stale payload may remain on the data outputs.
- Stall: while wb_valid_o=1 and wb_ready_i=0, all wb_* outputs hold stable, req_gnt_o=0, and ptr holds.
- ptr changes only on a grant.
- Requester contract:
  - A requester may withdraw valid before being granted.
  - Payload is sampled only in the grant cycle.
  - A requester holding valid is granted within NrReq grants (starvation-free).
- Zero strobes: a request with wstrb=0 is arbitrated and forwarded like any other; no filtering.
- Simultaneous events: refill and drain in the same cycle gives back-to-back writes with no bubble.
- No internal queueing beyond the single output register.

Test Plan:
- Reset, then hold req_valid_i=0 for 5 cycles -> wb_valid_o=0, req_gnt_o=0, busy_o=0 throughout.
- Single requester: req_valid_i=4'b0001, addr=0x010, id=2, wb_ready_i=1 -> req_gnt_o=4'b0001 in cycle 0; next cycle wb_valid_o=1, wb_addr_o=0x010, wb_id_o=2, wb_src_o=0.
- All four requesters continuously valid, wb_ready_i=1, starting from reset -> grant order 0,1,2,3,0,1 on consecutive cycles; wb_valid_o stays 1 with no bubbles.
- Stall: output holds a write from requester 2, wb_ready_i=0 for 3 cycles while 4'b1111 is valid -> wb_* stable, req_gnt_o=0; when wb_ready_i goes to 1, that cycle grants requester 3 (ptr=3).
- Valid withdrawn: requester 1 raises valid during a stall, then drops it before the stall ends -> requester 1 is never granted and nothing is written from it.
- Assert rst_i while wb_valid_o=1 and wb_ready_i=0 -> next cycle wb_valid_o=0, ptr=0; the next 4'b1010 request grants requester 1.
